// File: rtl/mux4_rr_arbiter_if.sv
// Bus bundle for mux4_rr_arbiter: requests and data words in, grant/select/data out.
// master: the requester side (drives req and data, observes grant and out).
// slave : the arbiter side.
interface mux4_rr_arbiter_if;
  logic [3:0] req;
  logic [5:0] in0;
  logic [5:0] in1;
  logic [5:0] in2;
  logic [5:0] in3;
  logic [3:0] grant;
  logic [1:0] sel;
  logic       valid;
  logic [5:0] out;

  modport master (
    output req, in0, in1, in2, in3,
    input  grant, sel, valid, out
  );

  modport slave (
    input  req, in0, in1, in2, in3,
    output grant, sel, valid, out
  );
endinterface

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing one 4:1 6-bit datapath between four requesters.
// Grant, select and valid are registered; out is the selected word gated by valid.
// Optional feature macro: MUX4_ARB_TIMEOUT_EN -- when defined, an owner that has
// held the datapath MAX_HOLD consecutive cycles is preempted if anyone else asks.
module mux4_rr_arbiter #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic               clk,
  input  logic               reset,
  mux4_rr_arbiter_if.slave   bus
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t           r_state;
  logic [3:0]       r_grant;
  logic [1:0]       r_sel;
  logic             r_valid;
  logic [1:0]       r_last;
  logic [CNT_W-1:0] r_cnt;

  state_t           w_state_next;
  logic [3:0]       w_grant_next;
  logic [1:0]       w_sel_next;
  logic             w_valid_next;
  logic [1:0]       w_last_next;
  logic [CNT_W-1:0] w_cnt_next;

  logic             w_preempt;
  logic [3:0]       w_cand;
  logic             w_any;
  logic [1:0]       w_idx [4];
  logic [3:0]       w_rot;
  logic [1:0]       w_win;
  logic [CNT_W-1:0] w_cnt_sat;
  logic [5:0]       w_mux;

`ifdef MUX4_ARB_TIMEOUT_EN
  // Owner has used its full hold budget, still wants the bus, and someone else is waiting.
  assign w_preempt = (r_state == BUSY) && bus.req[r_sel] &&
                     (r_cnt == CNT_W'(MAX_HOLD)) && (|(bus.req & ~r_grant));
`else
  assign w_preempt = 1'b0;
`endif

  // On preemption the current owner is excluded; on release its req bit is already low.
  assign w_cand = w_preempt ? (bus.req & ~r_grant) : bus.req;
  assign w_any  = |w_cand;

  // Rotate candidates so position 0 is the requester right after the last winner.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_rot
      assign w_idx[gi] = r_last + 2'(gi + 1);
      assign w_rot[gi] = w_cand[w_idx[gi]];
    end
  endgenerate

  // Pick the first set candidate in rotated order.
  always_comb begin
    w_win = w_idx[3];
    if (w_rot[0])      w_win = w_idx[0];
    else if (w_rot[1]) w_win = w_idx[1];
    else if (w_rot[2]) w_win = w_idx[2];
    else               w_win = w_idx[3];
  end

  assign w_cnt_sat = (r_cnt == CNT_W'(MAX_HOLD)) ? r_cnt : r_cnt + 1'b1;

  // Next-state and next-output decode for the IDLE/BUSY controller.
  always_comb begin
    w_state_next = r_state;
    w_grant_next = r_grant;
    w_sel_next   = r_sel;
    w_valid_next = r_valid;
    w_last_next  = r_last;
    w_cnt_next   = r_cnt;
    unique case (r_state)
      IDLE: begin
        if (w_any) begin
          w_state_next = BUSY;
          w_grant_next = 4'b0001 << w_win;
          w_sel_next   = w_win;
          w_valid_next = 1'b1;
          w_last_next  = w_win;
          w_cnt_next   = CNT_W'(1);
        end
      end
      BUSY: begin
        if (bus.req[r_sel] && !w_preempt) begin
          w_cnt_next = w_cnt_sat;
        end else if (w_any) begin
          // Release or preemption with a waiting requester: hand over with no bubble.
          w_grant_next = 4'b0001 << w_win;
          w_sel_next   = w_win;
          w_valid_next = 1'b1;
          w_last_next  = w_win;
          w_cnt_next   = CNT_W'(1);
        end else begin
          // Released and nobody waiting: go idle, keep sel where it was.
          w_state_next = IDLE;
          w_grant_next = 4'b0000;
          w_valid_next = 1'b0;
          w_cnt_next   = '0;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // State and output registers; reset wins over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_grant <= 4'b0000;
      r_sel   <= 2'd0;
      r_valid <= 1'b0;
      r_last  <= 2'd3;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_grant <= w_grant_next;
      r_sel   <= w_sel_next;
      r_valid <= w_valid_next;
      r_last  <= w_last_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Shared 4:1 datapath driven by the registered select.
  always_comb begin
    unique case (r_sel)
      2'd0:    w_mux = bus.in0;
      2'd1:    w_mux = bus.in1;
      2'd2:    w_mux = bus.in2;
      default: w_mux = bus.in3;
    endcase
  end

  assign bus.grant = r_grant;
  assign bus.sel   = r_sel;
  assign bus.valid = r_valid;
  assign bus.out   = r_valid ? w_mux : 6'd0;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter: stimulus pushes expected grant/sel per cycle
// into a scoreboard queue, a negedge monitor pops and compares.
module tb_mux4_rr_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  logic [5:0] data [4];

  typedef struct {
    int         due;
    int         tid;
    logic [3:0] g;
    logic [1:0] s;
  } exp_t;

  exp_t sb [$];

  mux4_rr_arbiter_if bus ();

  mux4_rr_arbiter #(
    .MAX_HOLD (4),
    .CNT_W    (3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Drive one cycle of inputs and queue the response expected after the next edge.
  task automatic step(input logic [3:0] r, input logic rs,
                      input logic [3:0] eg, input logic [1:0] es, input int tid);
    exp_t e;
    @(posedge clk);
    #1;
    bus.req = r;
    reset   = rs;
    e.due = cyc + 1;
    e.tid = tid;
    e.g   = eg;
    e.s   = es;
    sb.push_back(e);
  endtask

  // Monitor: compare DUT outputs against the scoreboard entry due this cycle.
  initial begin
    exp_t       e;
    logic       ev;
    logic [5:0] eo;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        n_checks++;
        ev = (e.g != 4'b0000);
        eo = ev ? data[e.s] : 6'd0;
        if (e.due < cyc) begin
          n_errors++;
          $display("FAIL late_entry test%0d due=%0d now=%0d", e.tid, e.due, cyc);
        end else if (bus.grant !== e.g || bus.sel !== e.s ||
                     bus.valid !== ev || bus.out !== eo) begin
          n_errors++;
          $display("FAIL test%0d cyc=%0d got grant=%b sel=%0d valid=%b out=%h want grant=%b sel=%0d valid=%b out=%h",
                   e.tid, cyc, bus.grant, bus.sel, bus.valid, bus.out, e.g, e.s, ev, eo);
        end else begin
          $display("ok test%0d cyc=%0d grant=%b sel=%0d valid=%b out=%h",
                   e.tid, cyc, bus.grant, bus.sel, bus.valid, bus.out);
        end
      end
    end
  end

  initial begin
    data[0] = 6'h15;
    data[1] = 6'h2A;
    data[2] = 6'h33;
    data[3] = 6'h0C;
    bus.req = 4'b0000;
    bus.in0 = data[0];
    bus.in1 = data[1];
    bus.in2 = data[2];
    bus.in3 = data[3];

    // Reset state
    step(4'b0000, 1'b1, 4'b0000, 2'd0, 0);
    step(4'b0000, 1'b1, 4'b0000, 2'd0, 0);
    step(4'b0000, 1'b0, 4'b0000, 2'd0, 0);

    // Single request from idle, one-cycle latency
    step(4'b0001, 1'b0, 4'b0001, 2'd0, 1);

`ifndef MUX4_ARB_TIMEOUT_EN
    // No preemption: owner 0 keeps the grant under full contention
    for (int i = 0; i < 20; i++) step(4'b1111, 1'b0, 4'b0001, 2'd0, 2);
`endif
    // Release hands over back-to-back
    step(4'b1110, 1'b0, 4'b0010, 2'd1, 2);

    // Rotation: each owner drops req for one cycle
    step(4'b1101, 1'b0, 4'b0100, 2'd2, 3);
    step(4'b1011, 1'b0, 4'b1000, 2'd3, 3);
    step(4'b0111, 1'b0, 4'b0001, 2'd0, 3);
    step(4'b1110, 1'b0, 4'b0010, 2'd1, 3);

    // Owner 2 releases with req=1001: 3 follows 2, then 0
    step(4'b1101, 1'b0, 4'b0100, 2'd2, 4);
    step(4'b1001, 1'b0, 4'b1000, 2'd3, 4);
    step(4'b0001, 1'b0, 4'b0001, 2'd0, 4);
    step(4'b0000, 1'b0, 4'b0000, 2'd0, 4);
    step(4'b0000, 1'b0, 4'b0000, 2'd0, 4);

    // Idle entry keeps sel of the last owner
    step(4'b0100, 1'b0, 4'b0100, 2'd2, 7);
    step(4'b0000, 1'b0, 4'b0000, 2'd2, 7);

    // A one-cycle pulse from another requester is never granted
    step(4'b0010, 1'b0, 4'b0010, 2'd1, 8);
    step(4'b0011, 1'b0, 4'b0010, 2'd1, 8);
    step(4'b0010, 1'b0, 4'b0010, 2'd1, 8);
    step(4'b0000, 1'b0, 4'b0000, 2'd1, 8);

    // Reset mid-grant, then pointer restarts with last=3
    step(4'b0100, 1'b0, 4'b0100, 2'd2, 6);
    step(4'b0010, 1'b0, 4'b0010, 2'd1, 6);
    step(4'b0010, 1'b1, 4'b0000, 2'd0, 6);
    step(4'b0101, 1'b0, 4'b0001, 2'd0, 6);
    step(4'b0000, 1'b0, 4'b0000, 2'd0, 6);
    step(4'b0100, 1'b0, 4'b0100, 2'd2, 6);

    // Contention between 0 and 1 from fresh reset
    step(4'b0000, 1'b1, 4'b0000, 2'd0, 5);
    for (int i = 0; i < 12; i++) begin
`ifdef MUX4_ARB_TIMEOUT_EN
      if (((i / 4) % 2) == 1) step(4'b0011, 1'b0, 4'b0010, 2'd1, 5);
      else                    step(4'b0011, 1'b0, 4'b0001, 2'd0, 5);
`else
      step(4'b0011, 1'b0, 4'b0001, 2'd0, 5);
`endif
    end
    for (int i = 0; i < 8; i++) step(4'b0001, 1'b0, 4'b0001, 2'd0, 5);
    step(4'b0000, 1'b0, 4'b0000, 2'd0, 5);

    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    n_checks++;
    if (sb.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain left=%0d want=0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
